// File: rtl/cl_ctrl_resp_pkg.sv
// Shared definitions for the cl_ctrl responder: register map, CTRL bit indices,
// FSM encodings and the CTRL status read layout.
package cl_ctrl_resp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;

  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 12'h000;
  localparam logic [ADDR_W-1:0] ADDR_CYCLES   = 12'h001;
  localparam logic [ADDR_W-1:0] ADDR_DONE_CNT = 12'h002;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_ACK_BIT   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [27:0] rsvd;
    logic        err;
    logic        done;
    logic        busy;
    logic        zero;
  } ctrl_stat_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cl_ctrl_resp_arg_bank.sv
// Kernel argument registers: write decode, combinational read mux and the
// snapshot register that presents the arguments to the kernel for a whole run.
module cl_ctrl_resp_arg_bank
  import cl_ctrl_resp_pkg::*;
#(
  parameter int unsigned       NUM_ARGS = 8,
  parameter logic [ADDR_W-1:0] ARG_BASE = 12'h010
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       snap_i,
  output logic [DATA_W-1:0]          rd_data_c_o,
  output logic [DATA_W*NUM_ARGS-1:0] args_o
);

  localparam int unsigned IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;

  logic [ADDR_W-1:0]          off_c;
  logic                       hit_c;
  logic [IDX_W-1:0]           idx_c;
  logic [DATA_W-1:0]          arg_q [NUM_ARGS];
  logic [DATA_W*NUM_ARGS-1:0] args_q;

  // Address window decode; misses read as zero.
  always_comb begin
    off_c       = addr_i - ARG_BASE;
    hit_c       = (addr_i >= ARG_BASE) && (32'(off_c) < NUM_ARGS);
    idx_c       = IDX_W'(off_c);
    rd_data_c_o = hit_c ? arg_q[idx_c] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ARGS; i++) arg_q[i] <= '0;
    end else if (wr_en_i && hit_c) begin
      for (int unsigned i = 0; i < NUM_ARGS; i++) begin
        if (idx_c == IDX_W'(i)) arg_q[i] <= wdata_i;
      end
    end
  end

  // Snapshot taken on an accepted start; later ARG writes do not disturb a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      args_q <= '0;
    end else if (snap_i) begin
      for (int unsigned i = 0; i < NUM_ARGS; i++) args_q[DATA_W*i +: DATA_W] <= arg_q[i];
    end
  end

  assign args_o = args_q;

endmodule

// File: rtl/cl_ctrl_resp.sv
// CL-side cl_ctrl register-bus responder: run-control FSM, profiling counters,
// error tracking and the BRAM-like registered read port.
module cl_ctrl_resp
  import cl_ctrl_resp_pkg::*;
#(
  parameter int unsigned       NUM_ARGS = 8,
  parameter logic [ADDR_W-1:0] ARG_BASE = 12'h010
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [ADDR_W-1:0]          cl_ctrl_addr,
  input  logic [DATA_W-1:0]          cl_ctrl_d,
  output logic [DATA_W-1:0]          cl_ctrl_q,
  input  logic                       cl_ctrl_ce,
  input  logic                       cl_ctrl_we,
  output logic                       cl_done,
  output logic                       kernel_start,
  output logic [DATA_W*NUM_ARGS-1:0] kernel_args,
  input  logic                       kernel_done
);

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] cycles_q, cycles_d;
  logic [DATA_W-1:0] done_cnt_q, done_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              kstart_q, cl_done_q;

  logic              wr_c, rd_c, start_wr_c, ack_wr_c;
  logic              start_acc_c, err_set_c, done_evt_c;
  logic [DATA_W-1:0] arg_rd_c;
  ctrl_stat_t        stat_c;

  assign wr_c       = cl_ctrl_ce & cl_ctrl_we;
  assign rd_c       = cl_ctrl_ce & ~cl_ctrl_we;
  assign start_wr_c = wr_c && (cl_ctrl_addr == ADDR_CTRL) && cl_ctrl_d[CTRL_START_BIT];
  assign ack_wr_c   = wr_c && (cl_ctrl_addr == ADDR_CTRL) && cl_ctrl_d[CTRL_ACK_BIT];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Start beats ack from DONE; kernel_done beats a start while BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_wr_c) state_d = ST_BUSY;
      ST_BUSY: if (kernel_done) state_d = ST_DONE;
      ST_DONE: begin
        if (start_wr_c)    state_d = ST_BUSY;
        else if (ack_wr_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_acc_c = start_wr_c && (state_q != ST_BUSY);
    done_evt_c  = kernel_done && (state_q == ST_BUSY);
    err_set_c   = (start_wr_c && (state_q == ST_BUSY)) || (kernel_done && (state_q != ST_BUSY));
  end

  // Datapath next-state: setting err wins over clearing it in the same cycle.
  always_comb begin
    err_d      = err_q;
    cycles_d   = cycles_q;
    done_cnt_d = done_cnt_q;
    if (err_set_c)                    err_d = 1'b1;
    else if (ack_wr_c || start_acc_c) err_d = 1'b0;
    if (start_acc_c)                  cycles_d = '0;
    else if (state_q == ST_BUSY)      cycles_d = sat_inc(cycles_q);
    if (done_evt_c)                   done_cnt_d = done_cnt_q + 32'd1;
  end

  always_comb begin
    stat_c      = '0;
    stat_c.err  = err_q;
    stat_c.done = (state_q == ST_DONE);
    stat_c.busy = (state_q == ST_BUSY);
    rdata_d     = rdata_q;
    if (rd_c) begin
      case (cl_ctrl_addr)
        ADDR_CTRL:     rdata_d = stat_c;
        ADDR_CYCLES:   rdata_d = cycles_q;
        ADDR_DONE_CNT: rdata_d = done_cnt_q;
        default:       rdata_d = arg_rd_c;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q      <= 1'b0;
      cycles_q   <= '0;
      done_cnt_q <= '0;
      rdata_q    <= '0;
      kstart_q   <= 1'b0;
      cl_done_q  <= 1'b0;
    end else begin
      err_q      <= err_d;
      cycles_q   <= cycles_d;
      done_cnt_q <= done_cnt_d;
      rdata_q    <= rdata_d;
      kstart_q   <= start_acc_c;
      cl_done_q  <= (state_d == ST_DONE);
    end
  end

  cl_ctrl_resp_arg_bank #(
    .NUM_ARGS (NUM_ARGS),
    .ARG_BASE (ARG_BASE)
  ) u_arg_bank (
    .clk         (clk),
    .rst_n       (resetn),
    .wr_en_i     (wr_c),
    .addr_i      (cl_ctrl_addr),
    .wdata_i     (cl_ctrl_d),
    .snap_i      (start_acc_c),
    .rd_data_c_o (arg_rd_c),
    .args_o      (kernel_args)
  );

  assign cl_ctrl_q    = rdata_q;
  assign cl_done      = cl_done_q;
  assign kernel_start = kstart_q;

endmodule

// File: tb/tb_cl_ctrl_resp.sv
// Bench for cl_ctrl_resp: table of bus accesses plus hand-written run sequences;
// read data is checked against a queue of expected values one cycle after each read.
module tb_cl_ctrl_resp;

  logic         clk = 1'b0;
  logic         resetn;
  logic [11:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  q;
  logic         ce, we;
  logic         cl_done, kernel_start, kdone;
  logic [255:0] kernel_args;

  int n_tests = 0;
  int n_fail  = 0;
  int ks_cnt  = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[$];

  cl_ctrl_resp #(.NUM_ARGS(8), .ARG_BASE(12'h010)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cl_ctrl_addr (addr),
    .cl_ctrl_d    (wdata),
    .cl_ctrl_q    (q),
    .cl_ctrl_ce   (ce),
    .cl_ctrl_we   (we),
    .cl_done      (cl_done),
    .kernel_start (kernel_start),
    .kernel_args  (kernel_args),
    .kernel_done  (kdone)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Tasks start and end at 1 time unit after a rising edge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
    sb_t e;
    e.exp = exp; e.name = nm;
    sb.push_back(e);
    ce = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_done();
    kdone = 1'b1;
    @(posedge clk); #1;
    kdone = 1'b0;
  endtask

  task automatic check_args_zero(input string nm);
    for (int i = 0; i < 8; i++) check($sformatf("%s%0d", nm, i), kernel_args[32*i +: 32], 32'h0);
  endtask

  // Read-data scoreboard: a read issued in cycle N is compared in cycle N+1.
  logic rd_seen;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) rd_seen <= 1'b0;
    else         rd_seen <= ce & ~we;
  end

  always @(negedge clk) begin
    if (kernel_start) ks_cnt++;
    if (rd_seen) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: got read data %h, expected no read", q);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check({"rd_", e.name}, q, e.exp);
      end
    end
  end

  initial begin
    tv = '{
      '{1'b0, 12'h000, 32'h0,         32'h0},
      '{1'b0, 12'h001, 32'h0,         32'h0},
      '{1'b0, 12'h002, 32'h0,         32'h0},
      '{1'b1, 12'h010, 32'hDEADBEEF,  32'h0},
      '{1'b1, 12'h017, 32'h12345678,  32'h0},
      '{1'b1, 12'h013, 32'hA5A50001,  32'h0},
      '{1'b0, 12'h010, 32'h0,         32'hDEADBEEF},
      '{1'b0, 12'h017, 32'h0,         32'h12345678},
      '{1'b0, 12'h013, 32'h0,         32'hA5A50001},
      '{1'b0, 12'h011, 32'h0,         32'h0},
      '{1'b1, 12'h018, 32'hFFFFFFFF,  32'h0},
      '{1'b0, 12'h018, 32'h0,         32'h0},
      '{1'b0, 12'h00F, 32'h0,         32'h0},
      '{1'b1, 12'h003, 32'h00001234,  32'h0},
      '{1'b0, 12'h003, 32'h0,         32'h0},
      '{1'b0, 12'h7FF, 32'h0,         32'h0},
      '{1'b1, 12'h000, 32'h00000002,  32'h0},
      '{1'b0, 12'h000, 32'h0,         32'h0},
      '{1'b0, 12'h017, 32'h0,         32'h12345678}
    };

    resetn = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; kdone = 1'b0;
    #3 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    check("rst_cl_done", 32'(cl_done), 32'h0);
    check("rst_kstart", 32'(kernel_start), 32'h0);
    check("rst_q", q, 32'h0);
    check_args_zero("rst_args");

    // Register map accesses while IDLE
    foreach (tv[i]) begin
      if (tv[i].we) wr(tv[i].addr, tv[i].data);
      else          rd(tv[i].addr, tv[i].exp, $sformatf("tv%0d", i));
    end
    idle(1);
    check("no_kstart_idle", 32'(ks_cnt), 32'h0);
    check("idle_cl_done", 32'(cl_done), 32'h0);

    // Start, snapshot, 10 busy cycles, done, ack
    wr(12'h000, 32'h1);
    check("start_pulse", 32'(kernel_start), 32'h1);
    check("args0", kernel_args[31:0], 32'hDEADBEEF);
    check("args3", kernel_args[127:96], 32'hA5A50001);
    check("args7", kernel_args[255:224], 32'h12345678);
    idle(1);
    check("start_1cyc", 32'(kernel_start), 32'h0);
    rd(12'h000, 32'h2, "ctrl_busy");
    idle(7);
    pulse_done();
    check("done_set", 32'(cl_done), 32'h1);
    rd(12'h001, 32'd10, "cycles10");
    rd(12'h002, 32'd1, "done_cnt1");
    rd(12'h000, 32'h4, "ctrl_done");
    check("done_held", 32'(cl_done), 32'h1);
    wr(12'h000, 32'h2);
    check("ack_clr", 32'(cl_done), 32'h0);
    rd(12'h000, 32'h0, "ctrl_acked");

    // Start while BUSY is ignored and flags err
    wr(12'h000, 32'h1);
    idle(2);
    wr(12'h000, 32'h1);
    check("busy_start_nopulse", 32'(kernel_start), 32'h0);
    rd(12'h000, 32'hA, "ctrl_err_busy");
    pulse_done();
    rd(12'h000, 32'hC, "ctrl_err_done");
    wr(12'h000, 32'h2);
    rd(12'h000, 32'h0, "ctrl_err_acked");
    rd(12'h002, 32'd2, "done_cnt2");

    // ARG write during a run only lands at the next start (restart from DONE)
    wr(12'h000, 32'h1);
    wr(12'h010, 32'h5);
    idle(1);
    check("args_stable", kernel_args[31:0], 32'hDEADBEEF);
    rd(12'h010, 32'h5, "arg0_new");
    pulse_done();
    wr(12'h000, 32'h1);
    check("restart_pulse", 32'(kernel_start), 32'h1);
    check("restart_args0", kernel_args[31:0], 32'h5);
    check("restart_cl_done", 32'(cl_done), 32'h0);
    rd(12'h000, 32'h2, "ctrl_restart");

    // kernel_done and a start write in the same BUSY cycle: done wins
    kdone = 1'b1;
    wr(12'h000, 32'h1);
    kdone = 1'b0;
    check("race_done", 32'(cl_done), 32'h1);
    check("race_nopulse", 32'(kernel_start), 32'h0);
    rd(12'h000, 32'hC, "ctrl_race");
    rd(12'h002, 32'd4, "done_cnt4");

    // start+ack together from DONE: start wins, err cleared
    wr(12'h000, 32'h3);
    check("startack_pulse", 32'(kernel_start), 32'h1);
    check("startack_cl_done", 32'(cl_done), 32'h0);
    rd(12'h000, 32'h2, "ctrl_startack");
    check("ks_total", 32'(ks_cnt), 32'd5);

    // Asynchronous reset mid-run, then a stray kernel_done
    idle(2);
    #2 resetn = 1'b0;
    #1;
    check("arst_q", q, 32'h0);
    check("arst_cl_done", 32'(cl_done), 32'h0);
    check("arst_kstart", 32'(kernel_start), 32'h0);
    check_args_zero("arst_args");
    @(posedge clk); #1;
    resetn = 1'b1;
    pulse_done();
    check("stray_done_nodone", 32'(cl_done), 32'h0);
    rd(12'h000, 32'h8, "ctrl_stray_err");
    rd(12'h001, 32'h0, "cycles_rst");
    rd(12'h002, 32'h0, "done_cnt_rst");
    rd(12'h010, 32'h0, "arg0_rst");
    wr(12'h000, 32'h2);
    rd(12'h000, 32'h0, "ctrl_err_ack");

    idle(2);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
